// File: rtl/add_serial_seq.sv
// add_serial_seq: sequences operand pairs through an external multi-cycle serial adder
// and holds each captured sum behind a valid/ready result interface.
`default_nettype none

module add_serial_seq #(
  parameter int ADD_CYCLES = 8,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             add_en,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             busy
);

  localparam int CW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ADD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] op_a, op_b, sum_q;
  logic             valid_q;
  logic             load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
      RUN: begin
        // Counter parks at LAST instead of wrapping while we leave RUN.
        if (cnt == LAST) state_nxt = CAPTURE;
        else             cnt_nxt   = cnt + 1'b1;
      end
      CAPTURE: begin
        if (!valid_q || res_ready) begin
          load      = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a <= '0;
      op_b <= '0;
    end else if (state == IDLE && in_valid) begin
      op_a <= in_a;
      op_b <= in_b;
    end
  end

  // A capture load in the same cycle as a consume keeps the result valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      sum_q   <= add_out;
      valid_q <= 1'b1;
    end else if (valid_q && res_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign add_en    = (state == LAUNCH) || (state == RELEASE);
  assign add_a     = op_a;
  assign add_b     = op_b;
  assign res_sum   = sum_q;
  assign res_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_add_serial_seq.sv
// Directed self-checking bench for add_serial_seq with a behavioural serial adder model.
`default_nettype none

module tb_add_serial_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       add_en;
  logic [7:0] add_a, add_b, add_out;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_sum;
  logic       busy;

  int tests = 0;
  int fails = 0;

  add_serial_seq #(.ADD_CYCLES(8), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_out(add_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Serial adder: first add_en starts it, result is presented only from
  // the ninth cycle after the start pulse, second add_en returns it to idle.
  logic       m_busy;
  logic [3:0] m_cnt;
  logic [7:0] m_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 4'd0;
      m_sum  <= 8'h00;
    end else if (add_en) begin
      if (!m_busy) begin
        m_busy <= 1'b1;
        m_cnt  <= 4'd1;
        m_sum  <= add_a + add_b;
      end else begin
        m_busy <= 1'b0;
        m_cnt  <= 4'd0;
      end
    end else if (m_busy && m_cnt < 4'd9) begin
      m_cnt <= m_cnt + 4'd1;
    end
  end

  assign add_out = (m_busy && m_cnt >= 4'd9) ? m_sum : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 10);
    chk(tag, res_sum, exp);
    @(negedge clk);
  endtask

  logic [7:0] pa [4] = '{8'h11, 8'h33, 8'hF0, 8'h7F};
  logic [7:0] pb [4] = '{8'h22, 8'h44, 8'h20, 8'h7F};
  logic [7:0] ps [4] = '{8'h33, 8'h77, 8'h10, 8'hFE};

  initial begin
    int en_cnt;
    int idx;

    // Reset values before any clock edge
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_add_en", add_en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Basic add with in_valid toggling during RUN
    @(negedge clk);
    in_a = 8'h35; in_b = 8'h4A; in_valid = 1'b1;
    chk("idle_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("launch_en", add_en, 1);
    chk("launch_busy", busy, 1);
    chk("launch_ready", in_ready, 0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 6) begin
        in_valid = k[0];
        in_a = 8'hFF; in_b = 8'hFF;
      end else begin
        in_valid = 1'b0;
      end
      chk($sformatf("basic_en_%0d", k), add_en, (k == 10) ? 1 : 0);
      if (k == 7) begin
        chk("ignore_a", add_a, 8'h35);
        chk("ignore_b", add_b, 8'h4A);
      end
      if (k == 10) begin
        chk("basic_valid", res_valid, 1);
        chk("basic_sum", res_sum, 8'h7F);
      end
      if (k == 11) begin
        chk("basic_idle", in_ready, 1);
        chk("basic_consumed", res_valid, 0);
      end
    end

    // Modulo-256 wrap cases
    run_op("wrap_ff01", 8'hFF, 8'h01, 8'h00);
    run_op("wrap_8080", 8'h80, 8'h80, 8'h00);
    run_op("wrap_aa55", 8'hAA, 8'h55, 8'hFF);

    // Backpressure: second result stalls in CAPTURE behind the first
    res_ready = 1'b0;
    run_op("bp_first", 8'h01, 8'h02, 8'h03);
    chk("bp_pending", res_valid, 1);
    in_a = 8'h10; in_b = 8'h20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk($sformatf("bp_en_%0d", k), add_en, 0);
    end
    chk("bp_busy", busy, 1);
    chk("bp_hold_sum", res_sum, 8'h03);
    chk("bp_hold_valid", res_valid, 1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_load_sum", res_sum, 8'h30);
    chk("bp_load_valid", res_valid, 1);
    chk("bp_release_en", add_en, 1);
    @(negedge clk);
    chk("bp_drained", res_valid, 0);
    chk("bp_idle", in_ready, 1);

    // Back-to-back: in_valid held high across four operations
    en_cnt = 0;
    for (int c = 0; c <= 47; c++) begin
      if (c > 0) @(negedge clk);
      idx = c / 12;
      if (idx < 4) begin
        in_a = pa[idx]; in_b = pb[idx];
      end
      in_valid = (c <= 36);
      if (add_en) en_cnt++;
      chk($sformatf("b2b_ready_%0d", c), in_ready, (c % 12 == 0 && c <= 36) ? 1 : 0);
      chk($sformatf("b2b_valid_%0d", c), res_valid, (c % 12 == 11) ? 1 : 0);
      if (c % 12 == 11) chk($sformatf("b2b_sum_%0d", idx), res_sum, ps[idx]);
    end
    chk("b2b_en_pulses", en_cnt, 8);
    @(negedge clk);
    chk("b2b_idle", in_ready, 1);

    // Reset in the RUN cycle with counter = 3, with a result pending
    res_ready = 1'b0;
    run_op("pre_rst", 8'h05, 8'h06, 8'h0B);
    in_a = 8'h77; in_b = 8'h11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_en", add_en, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_sum", res_sum, 0);
    chk("mid_rst_add_a", add_a, 0);
    @(negedge clk);
    chk("mid_rst_hold", busy, 0);
    rst = 1'b1;
    res_ready = 1'b1;
    run_op("post_rst", 8'h10, 8'h20, 8'h30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/add_serial_seq.md
ADD_SERIAL_SEQ -- requirements
Module: add_serial_seq

Interface
REQ-001 The block SHALL have parameter ADD_CYCLES, default 8, giving the number of serial add cycles the downstream adder needs per operation.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the operand and result width; it is fixed to match the adder.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-007 The block SHALL have ports in_a and in_b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port add_en, output, 1 bit: the enable pulse to the serial adder.
REQ-009 The block SHALL have ports add_a and add_b, output, WIDTH bits each: the operands driven to the serial adder.
REQ-010 The block SHALL have port add_out, input, WIDTH bits: the result from the serial adder.
REQ-011 The block SHALL have port res_valid, output, 1 bit: res_sum holds an unconsumed result.
REQ-012 The block SHALL have port res_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-013 The block SHALL have port res_sum, output, WIDTH bits: the captured sum.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE=0, LAUNCH=1, RUN=2, CAPTURE=3, RELEASE=4, held in a 3-bit register.
REQ-016 in_ready SHALL be 1 exactly when the state is IDLE.
REQ-017 In IDLE with in_valid=1, the block SHALL latch in_a and in_b into operand registers and go to LAUNCH; otherwise it SHALL stay in IDLE.
REQ-018 add_a and add_b SHALL be driven from the operand registers and SHALL hold stable from LAUNCH through RELEASE.
REQ-019 add_en SHALL be a decode of the state register only, high in LAUNCH and RELEASE and low in all other states, so it is one cycle wide each time.
REQ-020 LAUNCH SHALL last one cycle, clear the cycle counter to 0, and go to RUN.
REQ-021 In RUN the counter SHALL increment each cycle, and the block SHALL go to CAPTURE in the cycle the counter equals ADD_CYCLES-1, giving exactly ADD_CYCLES RUN cycles.
REQ-022 The counter SHALL be wide enough to hold ADD_CYCLES-1 and SHALL NOT wrap inside RUN.
REQ-023 Timing: with LAUNCH at cycle T, add_out SHALL be sampled in CAPTURE no earlier than cycle T+ADD_CYCLES+1.
REQ-024 In CAPTURE, if res_valid=0, or if res_valid=1 and res_ready=1, the block SHALL load res_sum with add_out, set res_valid=1, and go to RELEASE; otherwise it SHALL stay in CAPTURE and leave add_en low.
REQ-025 RELEASE SHALL last one cycle, returning the adder from its done state to idle, then go to IDLE.
REQ-026 res_valid SHALL clear in a cycle with res_valid=1 and res_ready=1, unless a CAPTURE load occurs in the same cycle, in which case the load wins and res_valid stays 1.
REQ-027 res_sum SHALL hold its value while res_valid=1 and no load occurs.
REQ-028 The sum SHALL be modulo 2^WIDTH, with the carry-out discarded.
REQ-029 in_valid SHALL be ignored in every state other than IDLE.
REQ-030 Throughput SHALL be one operation per ADD_CYCLES+4 cycles when res_ready is held at 1.
REQ-031 busy SHALL be high in every state other than IDLE.

Reset
REQ-032 While rst=0, independent of clk, the block SHALL set state=IDLE, counter=0, operand registers=0, res_sum=0, and res_valid=0.
REQ-033 The resulting output values during reset SHALL be add_en=0, in_ready=1, and busy=0.
REQ-034 The block SHALL be reset together with the adder, with the integration inverting rst for the adder's active-high reset, so an in-flight operation is discarded and no result is produced.
REQ-035 After reset deasserts, the first rising clk edge SHALL be a normal IDLE cycle.

Verification
REQ-036 Basic add: in_a=0x35, in_b=0x4A, res_ready=1 -> add_en pulses at T and at T+10; res_valid=1 with res_sum=0x7F from cycle T+10.
REQ-037 Wrap: 0xFF+0x01 -> res_sum=0x00; 0x80+0x80 -> res_sum=0x00; 0xAA+0x55 -> res_sum=0xFF.
REQ-038 Backpressure: res_ready=0 with a result pending and a second operation reaching CAPTURE -> the FSM holds in CAPTURE, add_en stays low, and the first res_sum is unchanged; raising res_ready loads the second result in the same cycle and res_valid stays 1.
REQ-039 Back-to-back: in_valid held at 1 with 4 operand pairs -> in_ready is high only in IDLE, results arrive in order 12 cycles apart, and add_en pulses exactly twice per operation.
REQ-040 Reset mid-run: rst=0 in the RUN cycle with counter=3 -> outputs take reset values immediately, and after release a new pair 0x10+0x20 yields 0x30.
REQ-041 Ignore when busy: toggling in_valid during RUN -> operands and result are unaffected.
